// File: rtl/uartm_tx_sched.sv
// Round-robin frame scheduler for the UART TX engine: grants one requester per frame and enforces timeout and inter-frame gap.
// Optional macro UARTM_SCHED_PRIO_EN gives requester 0 strict priority over round-robin among requesters 1-3.
module uartm_tx_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 sched_en,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   req_data_i,
    input  logic [15:0]          uartm_gap,
    input  logic [31:0]          uartm_tmo,
    input  logic                 tx_done_i,
    input  logic                 err_clr_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 tx_start_o,
    output logic [31:0]          tx_data_o,
    output logic [1:0]           cur_id_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   gap_len_q, gap_len_d;
    logic [NREQ-1:0]    gnt_d;
    logic               start_d;
    logic [31:0]        data_d;
    logic [1:0]         id_d;
    logic               busy_d;
    logic               err_d;
    logic               leave_wait;

    logic               found;
    logic [1:0]         win;
    logic [1:0]         idx;
    logic               rr_ok;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = '0;
        rr_ok = 1'b0;
`ifdef UARTM_SCHED_PRIO_EN
        if (req_i[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        for (int unsigned i = 1; i <= 4; i++) begin
            idx   = last_q + 2'(i);
            rr_ok = req_i[idx];
`ifdef UARTM_SCHED_PRIO_EN
            if (idx == 2'd0) rr_ok = 1'b0;
`endif
            if (!found && rr_ok) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wait_d     = wait_q;
        tmo_d      = tmo_q;
        gap_cnt_d  = gap_cnt_q;
        gap_len_d  = gap_len_q;
        gnt_d      = '0;
        start_d    = 1'b0;
        data_d     = tx_data_o;
        id_d       = cur_id_o;
        err_d      = err_o;
        leave_wait = 1'b0;

        if (err_clr_i) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sched_en && found) begin
                    gnt_d   = NREQ'(1) << win;
                    start_d = 1'b1;
                    data_d  = req_data_i[{win, 5'd0} +: 32];
                    id_d    = win;
                    last_d  = win;
                    wait_d  = '0;
                    tmo_d   = CNT_W'(uartm_tmo);
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wait_d = wait_q + CNT_W'(1);
                if (tx_done_i) begin
                    leave_wait = 1'b1;
                end else if (tmo_q != '0 && wait_q == tmo_q - CNT_W'(1)) begin
                    leave_wait = 1'b1;
                    err_d      = 1'b1;
                end
                if (leave_wait) begin
                    if (uartm_gap == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        gap_len_d = CNT_W'(uartm_gap);
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == gap_len_q - CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            wait_q     <= '0;
            tmo_q      <= '0;
            gap_cnt_q  <= '0;
            gap_len_q  <= '0;
            gnt_o      <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '1;
            cur_id_o   <= '0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            tmo_q      <= tmo_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_len_q  <= gap_len_d;
            gnt_o      <= gnt_d;
            tx_start_o <= start_d;
            tx_data_o  <= data_d;
            cur_id_o   <= id_d;
            busy_o     <= busy_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_uartm_tx_sched.sv
// Directed self-checking bench for uartm_tx_sched: grant order, latency, timeout, gap and reset behaviour.
module tb_uartm_tx_sched;

`ifdef UARTM_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic         hclk;
    logic         hresetn;
    logic         sched_en;
    logic [3:0]   req_i;
    logic [127:0] req_data_i;
    logic [15:0]  uartm_gap;
    logic [31:0]  uartm_tmo;
    logic         tx_done_i;
    logic         err_clr_i;
    logic [3:0]   gnt_o;
    logic         tx_start_o;
    logic [31:0]  tx_data_o;
    logic [1:0]   cur_id_o;
    logic         busy_o;
    logic         err_o;

    int n_assert = 0;
    int n_fail   = 0;

    uartm_tx_sched #(.NREQ(4), .CNT_W(32)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .sched_en   (sched_en),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .uartm_gap  (uartm_gap),
        .uartm_tmo  (uartm_tmo),
        .tx_done_i  (tx_done_i),
        .err_clr_i  (err_clr_i),
        .gnt_o      (gnt_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .cur_id_o   (cur_id_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic done_pulse();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int c;
        c = 0;
        while (tx_start_o !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        chk(tag, 32'(tx_start_o), 32'd1);
    endtask

    initial begin
        int lat;
        logic [1:0] exp_id;

        hresetn    = 1'b0;
        sched_en   = 1'b0;
        req_i      = '0;
        req_data_i = {32'hD3D3_0003, 32'hA5A5_0F0F, 32'hD1D1_0001, 32'hD0D0_0000};
        uartm_gap  = '0;
        uartm_tmo  = '0;
        tx_done_i  = 1'b0;
        err_clr_i  = 1'b0;
        repeat (3) @(posedge hclk);
        #1;

        chk("rst_gnt",   32'(gnt_o),      32'h0);
        chk("rst_start", 32'(tx_start_o), 32'h0);
        chk("rst_data",  tx_data_o,       32'hFFFF_FFFF);
        chk("rst_id",    32'(cur_id_o),   32'h0);
        chk("rst_busy",  32'(busy_o),     32'h0);
        chk("rst_err",   32'(err_o),      32'h0);

        hresetn = 1'b1;
        tick();

        // Single request at index 2, one-cycle grant latency
        sched_en = 1'b1;
        req_i    = 4'b0100;
        tick();
        chk("a_gnt",   32'(gnt_o),      32'h4);
        chk("a_start", 32'(tx_start_o), 32'h1);
        chk("a_data",  tx_data_o,       32'hA5A5_0F0F);
        chk("a_id",    32'(cur_id_o),   32'h2);
        chk("a_busy",  32'(busy_o),     32'h1);
        req_i = '0;
        tick();
        chk("a_start_pulse", 32'(tx_start_o), 32'h0);
        chk("a_gnt_pulse",   32'(gnt_o),      32'h0);
        chk("a_data_hold",   tx_data_o,       32'hA5A5_0F0F);
        done_pulse();
        chk("a_idle_busy", 32'(busy_o),   32'h0);
        chk("a_id_hold",   32'(cur_id_o), 32'h2);

        // Reset in WAIT_DONE aborts the frame immediately
        req_i = 4'b1111;
        wait_start("d_start");
        chk("d_id", 32'(cur_id_o), PRIO ? 32'd0 : 32'd3);
        tick();
        tick();
        hresetn = 1'b0;
        #1;
        chk("d_busy", 32'(busy_o), 32'h0);
        chk("d_data", tx_data_o,   32'hFFFF_FFFF);
        chk("d_gnt",  32'(gnt_o),  32'h0);
        tick();
        hresetn = 1'b1;

        // Round-robin order after reset with every requester active
        for (int k = 0; k < 5; k++) begin
            exp_id = PRIO ? 2'd0 : 2'(k % 4);
            wait_start("b_start");
            chk("b_id",  32'(cur_id_o), 32'(exp_id));
            chk("b_gnt", 32'(gnt_o),    32'(4'b0001 << exp_id));
            if (k == 4) req_i = '0;
            repeat (9) tick();
            done_pulse();
        end

        // Gap of 5: next start 6 edges after done; done and gap changes during GAP ignored
        uartm_gap = 16'd5;
        req_i     = 4'b0010;
        wait_start("g_start");
        chk("g_id", 32'(cur_id_o), 32'h1);
        tick();
        done_pulse();
        lat = 0;
        while (tx_start_o !== 1'b1 && lat < 20) begin
            tx_done_i = (lat == 1);
            if (lat == 2) uartm_gap = 16'd0;
            tick();
            lat++;
            if (lat == 3) chk("g_busy_in_gap", 32'(busy_o), 32'h1);
        end
        tx_done_i = 1'b0;
        chk("g_latency",  32'(lat),      32'd6);
        chk("g_id_again", 32'(cur_id_o), 32'h1);
        req_i = '0;
        tick();
        done_pulse();
        chk("g_idle", 32'(busy_o), 32'h0);

        // Timeout of 100 cycles sets sticky err_o
        uartm_tmo = 32'd100;
        req_i     = 4'b1000;
        wait_start("t_start");
        chk("t_id", 32'(cur_id_o), 32'h3);
        req_i = '0;
        repeat (99) tick();
        chk("t_err_early", 32'(err_o),  32'h0);
        chk("t_busy_wait", 32'(busy_o), 32'h1);
        tick();
        chk("t_err_set",   32'(err_o),  32'h1);
        chk("t_busy_exit", 32'(busy_o), 32'h0);
        tick();
        chk("t_err_sticky", 32'(err_o), 32'h1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("t_err_clr", 32'(err_o), 32'h0);

        // Done coinciding with the timeout edge wins
        uartm_tmo = 32'd3;
        req_i     = 4'b0100;
        wait_start("c_start");
        req_i = '0;
        tick();
        tick();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("c_no_err", 32'(err_o),  32'h0);
        chk("c_idle",   32'(busy_o), 32'h0);
        uartm_tmo = 32'd0;

        // sched_en low blocks new grants
        sched_en = 1'b0;
        req_i    = 4'b0001;
        repeat (3) tick();
        chk("s_blocked_busy", 32'(busy_o),     32'h0);
        chk("s_blocked_strt", 32'(tx_start_o), 32'h0);
        sched_en = 1'b1;
        tick();
        chk("s_start", 32'(tx_start_o), 32'h1);
        chk("s_id",    32'(cur_id_o),   32'h0);
        req_i = '0;
        done_pulse();

        // Two requesters held: alternate without priority, always 0 with it
        hresetn = 1'b0;
        tick();
        hresetn = 1'b1;
        tick();
        req_i = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            exp_id = PRIO ? 2'd0 : 2'(k % 2);
            wait_start("p_start");
            chk("p_id", 32'(cur_id_o), 32'(exp_id));
            if (k == 3) req_i = '0;
            repeat (2) tick();
            done_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uartm_tx_sched.md
UARTM_TX_SCHED -- requirements
Module: uartm_tx_sched

Interface
REQ-001 The block SHALL have a single clock hclk; reset hresetn SHALL be asynchronous and active-low.
REQ-002 Parameter NREQ, default 4, SHALL be the number of requesters; only 4 is supported.
REQ-003 Parameter CNT_W, default 32, SHALL be the width of the wait and gap counters.
REQ-004 hclk  in  1  clock.
REQ-005 hresetn  in  1  async active-low reset.
REQ-006 sched_en  in  1  enable for new grants.
REQ-007 req_i  in  4  level request, one bit per requester.
REQ-008 req_data_i  in  128  word for requester k on bits [32k+31:32k].
REQ-009 uartm_gap  in  16  idle cycles between frames.
REQ-010 uartm_tmo  in  32  frame timeout in cycles; 0 disables the timeout.
REQ-011 tx_done_i  in  1  one-cycle pulse from the TX engine after the stop bit.
REQ-012 err_clr_i  in  1  clears err_o.
REQ-013 gnt_o  out  4  one-hot grant pulse.
REQ-014 tx_start_o  out  1  frame-start pulse to the TX engine.
REQ-015 tx_data_o  out  32  word to transmit.
REQ-016 cur_id_o  out  2  index of the last granted requester.
REQ-017 busy_o  out  1  high when the FSM is not in IDLE.
REQ-018 err_o  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT_DONE and GAP. All outputs SHALL be registered.
REQ-020 IDLE with sched_en=1 and a nonzero req_i at edge N: during cycle N+1 the block SHALL drive gnt_o[w]=1 and tx_start_o=1 for exactly one cycle, load tx_data_o with requester w's word and cur_id_o with w, and enter WAIT_DONE.
REQ-021 Arbitration SHALL be round-robin: the search starts at (last grant + 1) mod 4; last grant updates on every grant.
REQ-022 tx_data_o and cur_id_o SHALL hold their values until the next grant.
REQ-023 WAIT_DONE: the wait counter SHALL increment each cycle from 0. On tx_done_i=1 the FSM SHALL go to GAP, or to IDLE if uartm_gap==0.
REQ-024 WAIT_DONE with uartm_tmo!=0: when the wait counter reaches uartm_tmo-1 without tx_done_i, err_o SHALL be set and the FSM SHALL leave WAIT_DONE exactly as on done.
REQ-025 If tx_done_i and the timeout occur in the same cycle, done SHALL win and err_o SHALL NOT be set.
REQ-026 GAP SHALL last exactly uartm_gap cycles and then return to IDLE. The earliest next tx_start_o is uartm_gap+1 cycles after the done cycle.
REQ-027 tx_done_i SHALL be ignored in IDLE and GAP.
REQ-028 sched_en=0 SHALL block new grants only; a frame already in progress completes normally.
REQ-029 A requester that drops req_i before it is granted SHALL NOT be granted; req_data_i is sampled only at the grant edge.
REQ-030 err_o SHALL clear on err_clr_i. If set and clear occur in the same cycle, set SHALL win.
REQ-031 uartm_gap and uartm_tmo SHALL be sampled on entry to GAP and WAIT_DONE respectively; later changes SHALL NOT affect the current count.

Reset
REQ-032 Reset SHALL force IDLE; gnt_o=0, tx_start_o=0, tx_data_o=32'hFFFF_FFFF, cur_id_o=0, busy_o=0, err_o=0, counters 0, last grant=3 (so requester 0 wins first).
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no further gnt_o or tx_start_o pulse.

Configuration
REQ-034 With UARTM_SCHED_PRIO_EN defined, req_i[0] SHALL always win when asserted, and requesters 1-3 SHALL share round-robin among themselves.
REQ-035 Without UARTM_SCHED_PRIO_EN, pure 4-way round-robin per REQ-021 SHALL apply.

Verification
REQ-036 After reset, req_i=4'b1111 with tx_done_i returned 10 cycles after each start and uartm_gap=0 -> grant order SHALL be 0,1,2,3,0.
REQ-037 req_i=4'b0100 with data 32'hA5A5_0F0F at index 2 -> one cycle later gnt_o=4'b0100, tx_start_o=1, tx_data_o=32'hA5A5_0F0F, cur_id_o=2, busy_o=1.
REQ-038 uartm_tmo=100 with no tx_done_i -> err_o=1 100 cycles after entering WAIT_DONE; err_clr_i pulse -> err_o=0.
REQ-039 uartm_gap=5 -> next tx_start_o exactly 6 cycles after the tx_done_i cycle; tx_done_i during GAP causes no effect.
REQ-040 With UARTM_SCHED_PRIO_EN defined and req_i=4'b0011 held -> every grant SHALL go to 0; without the macro -> grants alternate 0,1.
REQ-041 hresetn asserted in WAIT_DONE -> busy_o=0 and tx_data_o=32'hFFFF_FFFF immediately; the first grant after release SHALL go to requester 0.
